gf2m_reduce_seq: RTL and testbench

//  Sequential GF(2)[x] modular reducer that sits directly downstream of the 64-bit

---
 rtl/gf2m_reduce_seq.sv | 90 +++++++++
 tb/tb_gf2m_reduce_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2m_reduce_seq.sv
// Digit-serial reducer of a 127-bit carry-less product modulo x^64 + POLY.
// Clears DIGIT high-order coefficients per cycle, MSB-first, with valid/ready on both sides.
module gf2m_reduce_seq #(
    parameter logic [63:0] POLY  = 64'h1B,
    parameter int unsigned DIGIT = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [126:0] in_prod_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [63:0]  out_rem_o,
    output logic         busy_o
);

    localparam int unsigned NCYC = (63 + DIGIT - 1) / DIGIT;
    localparam int unsigned CntW = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [126:0] PolyExt = {62'b0, 1'b1, POLY};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [126:0]    acc_q, acc_d, acc_step;
    logic [CntW-1:0] cnt_q, cnt_d;
    int              idx;

    // Chained within the cycle so a bit set by a higher reduction is cleared in the same digit.
    always_comb begin
        acc_step = acc_q;
        idx      = 0;
        for (int j = 0; j < int'(DIGIT); j++) begin
            idx = 126 - int'(cnt_q) * int'(DIGIT) - j;
            if (idx >= 64) begin
                if (acc_step[idx[6:0]]) begin
                    acc_step = acc_step ^ (PolyExt << (idx - 64));
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    acc_d   = in_prod_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_step;
                if (cnt_q == CntW'(NCYC - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gated by rst_n so the producer sees no ready while the block is held in reset.
    assign in_ready_o  = (state_q == StIdle) && rst_n;
    assign out_valid_o = (state_q == StDone);
    assign busy_o      = (state_q == StRun);
    assign out_rem_o   = out_valid_o ? acc_q[63:0] : 64'h0;

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Directed and random checks of gf2m_reduce_seq; a DIGIT=10 instance covers the short last digit.
module tb_gf2m_reduce_seq;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [126:0] in_prod   = '0;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [63:0] rem_a;
    logic        in_ready_b, out_valid_b, busy_b;
    logic [63:0] rem_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gf2m_reduce_seq u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_a),
        .in_prod_i  (in_prod),
        .out_valid_o(out_valid_a),
        .out_ready_i(out_ready),
        .out_rem_o  (rem_a),
        .busy_o     (busy_a)
    );

    gf2m_reduce_seq #(
        .POLY (64'h1B),
        .DIGIT(10)
    ) u_dut10 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready_b),
        .in_prod_i  (in_prod),
        .out_valid_o(out_valid_b),
        .out_ready_i(out_ready),
        .out_rem_o  (rem_b),
        .busy_o     (busy_b)
    );

    typedef struct {
        logic [126:0] prod;
        logic [63:0]  rem;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_reduce(input logic [126:0] p);
        logic [126:0] a;
        a = p;
        for (int i = 126; i >= 64; i--) begin
            if (a[i]) a = a ^ ({62'b0, 1'b1, 64'h1B} << (i - 64));
        end
        return a[63:0];
    endfunction

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(in_ready_a && in_ready_b) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " idle"}, 64'(in_ready_a && in_ready_b), 64'd1);
    endtask

    // Sends one product to both instances and checks result, latency, stall stability
    // and the single-cycle out_valid pulse.
    task automatic run_one(input logic [126:0] p, input logic [63:0] exp, input string name,
                           input bit rnd);
        int          cyc;
        bit          done_a, done_b, stall_a, stall_b, post_a, post_b, seen_a, seen_b;
        logic [63:0] hold_a, hold_b;
        done_a = 0; done_b = 0; stall_a = 0; stall_b = 0;
        post_a = 0; post_b = 0; seen_a = 0; seen_b = 0;
        hold_a = '0; hold_b = '0;
        wait_idle(name);
        in_prod  = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_prod  = ~p;
        cyc = 0;
        while (!(done_a && done_b && !post_a && !post_b) && cyc < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (post_a) begin
                chk({name, " valid drop"}, 64'(out_valid_a), 64'd0);
                post_a = 0;
            end
            if (post_b) begin
                chk({name, " valid drop d10"}, 64'(out_valid_b), 64'd0);
                post_b = 0;
            end
            if (!done_a && out_valid_a) begin
                if (!seen_a) begin
                    seen_a = 1;
                    chk({name, " latency"}, 64'(cyc), 64'd9);
                end
                if (stall_a) chk({name, " stable"}, rem_a, hold_a);
                if (out_ready) begin
                    chk({name, " rem"}, rem_a, exp);
                    done_a = 1;
                    post_a = 1;
                end else begin
                    stall_a = 1;
                    hold_a  = rem_a;
                end
            end else if (!done_a && stall_a) begin
                chk({name, " valid held"}, 64'(out_valid_a), 64'd1);
                stall_a = 0;
            end
            if (!done_b && out_valid_b) begin
                if (!seen_b) begin
                    seen_b = 1;
                    chk({name, " latency d10"}, 64'(cyc), 64'd7);
                end
                if (stall_b) chk({name, " stable d10"}, rem_b, hold_b);
                if (out_ready) begin
                    chk({name, " rem d10"}, rem_b, exp);
                    done_b = 1;
                    post_b = 1;
                end else begin
                    stall_b = 1;
                    hold_b  = rem_b;
                end
            end else if (!done_b && stall_b) begin
                chk({name, " valid held d10"}, 64'(out_valid_b), 64'd1);
                stall_b = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " completed"}, 64'(done_a && done_b), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [126:0] p;
        int           n;

        vecs[0] = '{127'h0, 64'h0};
        vecs[1] = '{127'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D};
        vecs[2] = '{127'd1 << 64, 64'h1B};
        vecs[3] = '{127'd1 << 65, 64'h36};
        vecs[4] = '{(127'd1 << 64) | 127'd1, 64'h1A};
        vecs[5] = '{127'd1 << 66, 64'h6C};
        vecs[6] = '{127'd1 << 70, 64'h6C0};
        vecs[7] = '{127'd1 << 123, 64'hD800000000000000};
        vecs[8] = '{127'd1 << 124, 64'hB00000000000001B};
        vecs[9] = '{127'd1 << 126, 64'hC00000000000005A};

        #1 rst_n = 1'b0;
        #2;
        chk("reset in_ready", 64'(in_ready_a), 64'd0);
        chk("reset out_valid", 64'(out_valid_a), 64'd0);
        chk("reset busy", 64'(busy_a), 64'd0);
        chk("reset out_rem", rem_a, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post-reset in_ready", 64'(in_ready_a), 64'd1);

        foreach (vecs[i]) run_one(vecs[i].prod, vecs[i].rem, $sformatf("vec%0d", i), 1'b0);

        // Busy during RUN
        wait_idle("busy");
        in_prod = 127'd1 << 64; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy in run", 64'(busy_a), 64'd1);
        chk("in_ready in run", 64'(in_ready_a), 64'd0);
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;

        p = '1;
        run_one(p, ref_reduce(p), "all-ones", 1'b1);
        for (int k = 0; k < 150; k++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            p[126] = (k % 3 == 0);
            run_one(p, ref_reduce(p), $sformatf("rand%0d", k), 1'b1);
        end

        // Long back-pressure; a second in_valid pulse while DONE must be dropped
        wait_idle("stall");
        in_prod = 127'd1 << 65; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall reached done", 64'(out_valid_a), 64'd1);
        for (int c = 0; c < 50; c++) begin
            chk("stall valid", 64'(out_valid_a), 64'd1);
            chk("stall in_ready", 64'(in_ready_a), 64'd0);
            chk("stall rem", rem_a, 64'h36);
            in_valid = (c == 20);
            in_prod  = 127'd1 << 64;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release valid", 64'(out_valid_a), 64'd0);
        chk("release in_ready", 64'(in_ready_a), 64'd1);
        run_one((127'd1 << 64) | 127'd1, 64'h1A, "after stall", 1'b0);

        // Reset in the middle of a reduction
        wait_idle("midreset");
        in_prod = 127'd1 << 126; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset busy", 64'(busy_a), 64'd0);
        chk("midreset in_ready", 64'(in_ready_a), 64'd0);
        chk("midreset valid", 64'(out_valid_a), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("midreset released in_ready", 64'(in_ready_a), 64'd1);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid_a) n++;
        end
        out_ready = 1'b0;
        chk("midreset no pulse", 64'(n), 64'd0);
        run_one(127'd1 << 64, 64'h1B, "after reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
